// File: rtl/arb_client.sv
// Leaf requester for one child port of an arbitration-tree cell.
// Latency: accepted job raises request on the next edge; the lock lasts len cycles and release lasts one cycle.
// Backpressure: job_ready is high only in IDLE; the request is held until ack arrives (never withdrawn).
module arb_client #(
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 16,
  parameter int STARVE_LIM = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  input  logic             ack,
  output logic [1:0]       req,
  output logic             in_lock,
  output logic             done,
  output logic [CNT_W-1:0] grant_cnt,
  output logic [CNT_W-1:0] max_wait,
  output logic             starve,
  output logic             proto_err
);

  // The state encoding is the handshake code driven on req.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_LOCK    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // The cell uses an inverted boolean: a low ack means "granted".
  localparam logic ACK_TRUE = 1'b0;
  localparam logic [CNT_W:0] LIM = (CNT_W+1)'(STARVE_LIM);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] maxw_q, maxw_d;
  logic             starve_q, starve_d;
  logic             perr_q, perr_d;

  logic [CNT_W:0]   wait_p1;
  logic [CNT_W-1:0] wait_inc;
  logic [CNT_W-1:0] grant_inc;
  logic             starve_hit;

  // Saturating increments; the unsaturated wait+1 is kept for the starve compare.
  always_comb begin
    wait_p1    = {1'b0, wait_q} + (CNT_W+1)'(1);
    wait_inc   = (wait_q == '1) ? wait_q : wait_p1[CNT_W-1:0];
    grant_inc  = (grant_q == '1) ? grant_q : grant_q + CNT_W'(1);
    starve_hit = (STARVE_LIM != 0) && (wait_p1 == LIM);
  end

  // Next-state and statistics update for the four-phase handshake.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    hold_d   = hold_q;
    wait_d   = wait_q;
    grant_d  = grant_q;
    maxw_d   = maxw_q;
    starve_d = starve_q;
    perr_d   = perr_q;

    // A grant outside REQUEST is a cell bug; flag it and otherwise ignore it.
    if (ack == ACK_TRUE && state_q != ST_REQUEST) begin
      perr_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          len_d   = (job_len == '0) ? LEN_W'(1) : job_len;
          wait_d  = '0;
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        // Starve may set in the same cycle as the grant; both take effect.
        if (starve_hit) begin
          starve_d = 1'b1;
        end
        if (ack == ACK_TRUE) begin
          state_d = ST_LOCK;
          hold_d  = len_q;
          grant_d = grant_inc;
          maxw_d  = (wait_inc > maxw_q) ? wait_inc : maxw_q;
        end else begin
          wait_d = wait_inc;
        end
      end
      ST_LOCK: begin
        hold_d = hold_q - LEN_W'(1);
        if (hold_q == LEN_W'(1)) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and statistics registers; reset is abrupt, the tree resets alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      hold_q   <= '0;
      wait_q   <= '0;
      grant_q  <= '0;
      maxw_q   <= '0;
      starve_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      hold_q   <= hold_d;
      wait_q   <= wait_d;
      grant_q  <= grant_d;
      maxw_q   <= maxw_d;
      starve_q <= starve_d;
      perr_q   <= perr_d;
    end
  end

  // Every output is decoded from registers; ack never reaches an output combinationally.
  assign req       = state_q;
  assign job_ready = (state_q == ST_IDLE);
  assign in_lock   = (state_q == ST_LOCK);
  assign done      = (state_q == ST_RELEASE);
  assign grant_cnt = grant_q;
  assign max_wait  = maxw_q;
  assign starve    = starve_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_arb_client.sv
// Bench for arb_client: job-level reference model plus a two-client arbitration cell.
// Expected handshake traces are built per job from wait count and length, not from DUT state.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_arb_client;

  localparam int LEN_W = 8;
  localparam int CNT_W = 16;
  localparam int LIM   = 64;
  localparam int CMAX  = 65535;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             job_valid = 1'b0;
  logic [LEN_W-1:0] job_len = '0;
  logic             ack = 1'b1;
  logic             job_ready, in_lock, done, starve, proto_err;
  logic [1:0]       req;
  logic [CNT_W-1:0] grant_cnt, max_wait;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state (statistics as integers).
  int m_grant = 0;
  int m_maxw  = 0;
  bit m_starve = 1'b0;
  bit m_perr   = 1'b0;

  always #5 clk = ~clk;

  arb_client #(.LEN_W(LEN_W), .CNT_W(CNT_W), .STARVE_LIM(LIM)) u_dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_len(job_len), .job_ready(job_ready),
    .ack(ack), .req(req), .in_lock(in_lock), .done(done), .grant_cnt(grant_cnt),
    .max_wait(max_wait), .starve(starve), .proto_err(proto_err)
  );

  // Two clients under one behavioural cell.
  logic             rst2 = 1'b1;
  logic             jv2 = 1'b0;
  logic [LEN_W-1:0] jl2 = 8'd2;
  logic [1:0]       rq_l, rq_r;
  logic             ack_l, ack_r, g_l, g_r, last_left_q;
  logic             rdy_l, rdy_r, lk_l, lk_r, dn_l, dn_r, sv_l, sv_r, pe_l, pe_r;
  logic [CNT_W-1:0] gc_l, gc_r, mw_l, mw_r;

  assign g_l   = (rq_l == 2'd1) && (rq_r != 2'd2) && !(rq_r == 2'd1 && last_left_q);
  assign g_r   = (rq_r == 2'd1) && (rq_l != 2'd2) && !(rq_l == 2'd1 && !last_left_q);
  assign ack_l = ~g_l;
  assign ack_r = ~g_r;

  always_ff @(posedge clk) begin
    if (rst2) last_left_q <= 1'b0;
    else if (g_l) last_left_q <= 1'b1;
    else if (g_r) last_left_q <= 1'b0;
  end

  arb_client #(.LEN_W(LEN_W), .CNT_W(CNT_W), .STARVE_LIM(LIM)) u_left (
    .clk(clk), .rst(rst2), .job_valid(jv2), .job_len(jl2), .job_ready(rdy_l),
    .ack(ack_l), .req(rq_l), .in_lock(lk_l), .done(dn_l), .grant_cnt(gc_l),
    .max_wait(mw_l), .starve(sv_l), .proto_err(pe_l)
  );

  arb_client #(.LEN_W(LEN_W), .CNT_W(CNT_W), .STARVE_LIM(LIM)) u_right (
    .clk(clk), .rst(rst2), .job_valid(jv2), .job_len(jl2), .job_ready(rdy_r),
    .ack(ack_r), .req(rq_r), .in_lock(lk_r), .done(dn_r), .grant_cnt(gc_r),
    .max_wait(mw_r), .starve(sv_r), .proto_err(pe_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Check the current cycle against the model, then drive inputs for the next edge.
  task automatic cyc(input logic [1:0] er, input logic v, input logic [7:0] l,
                     input logic a, input logic r);
    chk("req",       32'(req),       32'(er));
    chk("in_lock",   32'(in_lock),   32'(er == 2'd2));
    chk("done",      32'(done),      32'(er == 2'd3));
    chk("job_ready", 32'(job_ready), 32'(er == 2'd0));
    chk("grant_cnt", 32'(grant_cnt), 32'(m_grant));
    chk("max_wait",  32'(max_wait),  32'(m_maxw));
    chk("starve",    32'(starve),    32'(m_starve));
    chk("proto_err", 32'(proto_err), 32'(m_perr));
    job_valid = v;
    job_len   = l;
    ack       = a;
    rst       = r;
    @(negedge clk);
  endtask

  // One job: w refused REQUEST cycles, then grant; lpos = LOCK cycle with a stray ack;
  // gpulse = stray ack in the first trailing IDLE cycle; rst_lock = reset in 2nd LOCK cycle.
  task automatic run_job(input int w, input int l, input int gap, input bit gpulse,
                         input int lpos, input bit rst_lock);
    int eff;
    logic a;
    eff = (l == 0) ? 1 : l;
    cyc(2'd0, 1'b1, 8'(l), 1'b1, 1'b0);
    for (int k = 1; k <= w; k++) begin
      cyc(2'd1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1, 1'b0);
      if (k == LIM) m_starve = 1'b1;
    end
    cyc(2'd1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
    if (w + 1 == LIM) m_starve = 1'b1;
    m_grant = (m_grant < CMAX) ? m_grant + 1 : CMAX;
    if (w + 1 > m_maxw) m_maxw = (w + 1 > CMAX) ? CMAX : w + 1;
    for (int j = 0; j < eff; j++) begin
      if (rst_lock && j == 1) begin
        cyc(2'd2, 1'b0, 8'd0, 1'b1, 1'b1);
        m_grant = 0; m_maxw = 0; m_starve = 1'b0; m_perr = 1'b0;
        cyc(2'd0, 1'b0, 8'd0, 1'b1, 1'b0);
        return;
      end
      a = (j == lpos) ? 1'b0 : 1'b1;
      cyc(2'd2, 1'($urandom_range(0, 1)), 8'($urandom), a, 1'b0);
      if (!a) m_perr = 1'b1;
    end
    cyc(2'd3, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1, 1'b0);
    for (int g = 0; g < gap; g++) begin
      a = (g == 0 && gpulse) ? 1'b0 : 1'b1;
      cyc(2'd0, 1'b0, 8'($urandom), a, 1'b0);
      if (!a) m_perr = 1'b1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    int grants, alt_err, both_lock, prev_side, side;
    repeat (2) @(negedge clk);
    // Reset state is checked by the first cycle; rst drops here.
    cyc(2'd0, 1'b0, 8'd0, 1'b1, 1'b0);

    run_job(0, 3, 1, 1'b0, -1, 1'b0);   // 1,2,2,2,3,0; grant 1, max_wait 1
    run_job(0, 0, 1, 1'b0, -1, 1'b0);   // zero length behaves as one
    run_job(1, 4, 2, 1'b1, -1, 1'b0);   // stray ack in IDLE
    run_job(0, 4, 1, 1'b0, 1, 1'b0);    // stray ack in LOCK
    run_job(1, 10, 0, 1'b0, -1, 1'b1);  // reset in 2nd LOCK cycle
    run_job(70, 2, 1, 1'b0, -1, 1'b0);  // starvation, max_wait 71
    for (int i = 0; i < 30; i++) begin
      run_job(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0),
              int'($urandom_range(0, 9)) - 3, 1'b0);
    end
    cyc(2'd0, 1'b0, 8'd0, 1'b1, 1'b0);

    // Two clients contending with constant demand.
    rst2 = 1'b1;
    jv2  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst2 = 1'b0;
    grants = 0; alt_err = 0; both_lock = 0; prev_side = -1;
    for (int c = 0; c < 400 && grants < 20; c++) begin
      @(negedge clk);
      if (rq_l == 2'd2 && rq_r == 2'd2) both_lock++;
      if (g_l || g_r) begin
        side = g_l ? 0 : 1;
        if (side == prev_side) alt_err++;
        prev_side = side;
        grants++;
      end
    end
    @(negedge clk);
    chk("pair_grants",     32'(grants),    32'd20);
    chk("pair_alternate",  32'(alt_err),   32'd0);
    chk("pair_both_lock",  32'(both_lock), 32'd0);
    chk("left_grant_cnt",  32'(gc_l),      32'd10);
    chk("right_grant_cnt", 32'(gc_r),      32'd10);
    chk("pair_proto_err",  32'({pe_l, pe_r}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/arb_client.md
Name: arb_client

Overview:
- Leaf-side requester that drives one child port of an arbitration-tree cell. It is the synthesizable replacement for the nondeterministic processor model.
- Takes jobs from a local producer and runs the four-phase handshake idle -> request -> lock -> release on the tree. It holds the token for a programmed number of cycles, then returns it.
- Keeps grant and latency statistics for fairness checks across the tree.

Parameters:
- LEN_W, 8, width of job length field.
- CNT_W, 16, width of statistics counters.
- STARVE_LIM, 64, wait cycles in REQUEST after which the starve flag sets; 0 disables the flag.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- job_valid  in  1  producer offers a job.
- job_len  in  LEN_W  lock cycles wanted; 0 is treated as 1.
- job_ready  out  1  block accepts a job this cycle (high only in IDLE).
- ack  in  1  grant from the arbitration cell, boolean encoding: myTRUE=1'b0, myFALSE=1'b1.
- req  out  2  handshake to the cell, handShakeType encoding: idle=0, request=1, lock=2, release=3.
- in_lock  out  1  high while req==lock; the producer may use the resource.
- done  out  1  one-cycle pulse in the RELEASE cycle.
- grant_cnt  out  CNT_W  grants received, saturating.
- max_wait  out  CNT_W  largest REQUEST dwell seen, saturating.
- starve  out  1  sticky; set when the REQUEST dwell reaches STARVE_LIM.
- proto_err  out  1  sticky; set when ack==myTRUE is seen outside REQUEST.

Behaviour:
- The state register is req itself. All outputs are decoded from registers; there is no combinational path from ack to any output.
- Reset, applied on any edge and at any state including LOCK, forces on the next edge:
  - req=idle, in_lock=0, done=0, job_ready=1;
  - grant_cnt=0, max_wait=0, wait_ctr=0, hold_ctr=0;
  - starve=0, proto_err=0.
- There is no graceful release on reset; the tree is reset together with the block.
- IDLE:
  - job_ready=1.
  - job_valid=1: capture len = (job_len==0 ? 1 : job_len), clear wait_ctr, go to REQUEST.
  - Otherwise stay in IDLE.
- REQUEST:
  - req=request, job_ready=0.
  - The cell drives ack combinationally from req, so ack is sampled in the same cycle.
  - ack==myTRUE:
    - go to LOCK;
    - hold_ctr <= len;
    - grant_cnt <= grant_cnt+1 (saturating);
    - max_wait <= max(max_wait, wait_ctr+1) (saturating).
  - Otherwise:
    - wait_ctr <= wait_ctr+1 (saturating at all-ones);
    - if STARVE_LIM!=0 and wait_ctr+1 == STARVE_LIM, set starve.
  - The request is never withdrawn; the block waits in REQUEST indefinitely.
- LOCK:
  - req=lock, in_lock=1.
  - hold_ctr decrements each cycle.
  - When hold_ctr==1, the next state is RELEASE.
  - LOCK therefore lasts exactly len cycles: job_len=5 gives 5 cycles, job_len=0 gives 1.
- RELEASE:
  - req=release and done=1 for exactly one cycle, then IDLE.
  - The earliest next request is 2 cycles after release (one IDLE cycle minimum); this guarantees the cell sees release before the next request.
- ack==myTRUE in IDLE, LOCK or RELEASE sets proto_err and is otherwise ignored.
- job_valid outside IDLE is ignored and the job is not queued; the producer must hold job_valid until it sees job_ready.
- Simultaneous starve set and ack in the same cycle: both take effect, and the grant is still taken.
- Counter arithmetic is CNT_W-bit unsigned and saturates; there is no wrap.

Test Plan:
- Reset, then job_valid=1 with job_len=3 and ack tied myTRUE:
  - req sequence from the accept edge is 1,2,2,2,3,0;
  - done is high only in the req=3 cycle;
  - grant_cnt=1, max_wait=1.
- job_len=0 with immediate ack -> exactly one cycle of req=2, then 3, then 0.
- ack held myFALSE for 70 cycles with STARVE_LIM=64, then myTRUE:
  - starve rises on the 64th REQUEST cycle and stays high;
  - max_wait=71; grant_cnt=1.
- rst asserted in the 2nd cycle of a len=10 LOCK:
  - next cycle req=0, in_lock=0, job_ready=1;
  - all counters are 0 and starve/proto_err are 0.
- ack pulsed myTRUE while in IDLE and again in LOCK -> proto_err=1 after the first pulse; the state sequence is unaffected.
- Two instances under one cell with constant job_valid and len=2:
  - grants alternate left/right;
  - after 20 grants each grant_cnt=10, and req=2 is never high on both at once.
